// File: rtl/alu_resp_pipe.sv
// alu_resp_pipe: one-stage registered ALU with credit-based request side
// and a first-word-fall-through response FIFO carrying tag/result/err.
module alu_resp_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    input  logic [TAGW-1:0]  req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic [TAGW-1:0]  resp_tag,
    output logic             resp_err,
    output logic [15:0]      op_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       ctl;
        logic [TAGW-1:0]  tag;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [TAGW-1:0]  tag;
        logic             err;
    } resp_t;

    logic            accept;
    logic            push;
    logic            pop;
    logic            s1_valid;
    s1_t             s1;
    resp_t           s1_resp;
    resp_t           head;
    resp_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;

    // Credit counts the in-flight stage-1 entry, so the FIFO can never overflow.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, s1_valid};
    assign req_ready = !reset && (occupancy < DEPTH_C);
    assign accept    = req_valid && req_ready;

    // Stage 1: operand capture
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1.a   <= SrcA;
                s1.b   <= SrcB;
                s1.ctl <= ALUControl;
                s1.tag <= req_tag;
            end
        end
    end

    // Stage 2: combinational execute feeding the FIFO write port
    logic op_add, op_sub, op_and, op_or, op_xor, op_slt;

    assign op_add = (s1.ctl == 3'b000);
    assign op_sub = (s1.ctl == 3'b001);
    assign op_and = (s1.ctl == 3'b010);
    assign op_or  = (s1.ctl == 3'b011);
    assign op_xor = (s1.ctl == 3'b100);
    assign op_slt = (s1.ctl == 3'b101);

    always_comb begin
        s1_resp     = '0;
        s1_resp.tag = s1.tag;
        unique case (1'b1)
            op_add:  s1_resp.res = s1.a + s1.b;
            op_sub:  s1_resp.res = s1.a + ~s1.b + WIDTH'(1);
            op_and:  s1_resp.res = s1.a & s1.b;
            op_or:   s1_resp.res = s1.a | s1.b;
            op_xor:  s1_resp.res = s1.a ^ s1.b;
            op_slt:  s1_resp.res = {{(WIDTH-1){1'b0}},
                                    ($signed(s1.a) < $signed(s1.b))};
            default: s1_resp.err = 1'b1;
        endcase
    end

    // Response FIFO
    assign push       = s1_valid;
    assign resp_valid = (count != '0);
    assign pop        = resp_valid && resp_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s1_resp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign ALUResult = resp_valid ? head.res : '0;
    assign Zero      = resp_valid && (head.res == '0);
    assign resp_tag  = resp_valid ? head.tag : '0;
    assign resp_err  = resp_valid && head.err;

    always_ff @(posedge clk) begin
        if (reset) begin
            op_count <= '0;
        end else if (accept) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule
